// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder at the far end of the M-stage memory controls.
//   Services one 32-bit word read or write per access after WAIT_CYC wait
//   states, holding mem_stall high so the pipeline keeps M-stage inputs stable.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two)
//   AW        word-index width, log2(DEPTH)
//   WAIT_CYC  wait states per access, 0..15
//
// Ports
//   clka          clock, rising edge
//   rst           asynchronous active-high reset
//   data_ram_ena  M-stage access request
//   memwrite      1 = write, 0 = read (qualified by data_ram_ena)
//   addr          byte address; word index = addr[AW+1:2], upper bits wrap
//   wdata         store data
//   rdata         load data, valid in the completion cycle only, else 0
//   mem_stall     stall request to the hazard unit
//   busy          FSM is in WAIT
//   misalign      (only with DMEM_ALIGN_CHECK_EN) access with addr[1:0] != 0
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   When defined, misaligned accesses complete immediately with no stall,
//   no write and rdata = 0, and the misalign port is present.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        data_ram_ena,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_stall,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Counter load value on entry to WAIT; unused when WAIT_CYC is 0.
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          mis;
  logic          access;
  logic          complete;

  assign idx = addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis      = data_ram_ena && (addr[1:0] != 2'b00);
  assign misalign = mis;
`else
  assign mis = 1'b0;
`endif

  // Byte-offset and upper address bits do not select a word.
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // A misaligned request is retired on the spot and never enters the FSM.
  assign access = data_ram_ena && !mis;

  assign complete = access &&
                    (((state_q == S_IDLE) && (WAIT_CYC == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0)));

  assign mem_stall = access &&
                     (((state_q == S_IDLE) && (WAIT_CYC != 0)) ||
                      ((state_q == S_WAIT) && (cnt_q != 4'd0)));

  assign busy = (state_q == S_WAIT);

  // Combinational read; on a write completion this returns the old word.
  assign rdata = complete ? mem_q[idx] : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (access && (WAIT_CYC > 0)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (!data_ram_ena) begin
          // Flush: abandon the access, nothing is written.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array is not reset; exactly one update, on the edge ending completion.
  always_ff @(posedge clka) begin
    if (complete && memwrite) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WAIT_CYC = 2 instance
  logic        ena2, we2;
  logic [31:0] addr2, wd2, rd2;
  logic        st2, bz2;
  // WAIT_CYC = 0 instance
  logic        ena0, we0;
  logic [31:0] addr0, wd0, rd0;
  logic        st0, bz0;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        mis2, mis0;
`endif

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_CYC(2)) u2 (
    .clka(clk), .rst(rst), .data_ram_ena(ena2), .memwrite(we2),
    .addr(addr2), .wdata(wd2), .rdata(rd2), .mem_stall(st2), .busy(bz2)
`ifdef DMEM_ALIGN_CHECK_EN
    , .misalign(mis2)
`endif
  );

  dmem_responder #(.DEPTH(256), .AW(8), .WAIT_CYC(0)) u0 (
    .clka(clk), .rst(rst), .data_ram_ena(ena0), .memwrite(we0),
    .addr(addr0), .wdata(wd0), .rdata(rd0), .mem_stall(st0), .busy(bz0)
`ifdef DMEM_ALIGN_CHECK_EN
    , .misalign(mis0)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full access on the WAIT_CYC=2 instance; returns with ena2 still high,
  // one time unit after the edge that ends the completion cycle.
  task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    logic known;
    idx   = int'(a[9:2]);
    known = m2.exists(idx);
    if (known) exp_q.push_back(m2[idx]);
    if (w) m2[idx] = d;
    ena2 = 1'b1; we2 = w; addr2 = a; wd2 = d;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      chk("stall2", 32'(st2), 32'(c < 2));
      chk("busy2", 32'(bz2), 32'(c > 0));
`ifdef DMEM_ALIGN_CHECK_EN
      chk("misalign2", 32'(mis2), 32'd0);
`endif
      if (c < 2) chk("rdata2_wait", rd2, 32'd0);
      else if (known) chk("rdata2", rd2, exp_q.pop_front());
      @(posedge clk); #1;
    end
    $display("acc2 %s addr=%h data=%h", w ? "WR" : "RD", a, d);
  endtask

  // Single-cycle access on the WAIT_CYC=0 instance.
  task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    logic known;
    idx   = int'(a[9:2]);
    known = m0.exists(idx);
    if (known) exp_q.push_back(m0[idx]);
    if (w) m0[idx] = d;
    ena0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
    @(negedge clk);
    chk("stall0", 32'(st0), 32'd0);
    chk("busy0", 32'(bz0), 32'd0);
    if (known) chk("rdata0", rd0, exp_q.pop_front());
    @(posedge clk); #1;
    $display("acc0 %s addr=%h data=%h", w ? "WR" : "RD", a, d);
  endtask

  initial begin
    rst = 1'b1;
    ena2 = 0; we2 = 0; addr2 = 0; wd2 = 0;
    ena0 = 0; we0 = 0; addr0 = 0; wd0 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall2", 32'(st2), 32'd0);
    chk("rst_busy2", 32'(bz2), 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    chk("rst_stall0", 32'(st0), 32'd0);
    chk("rst_busy0", 32'(bz0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released");

    // Reset in the middle of a write aborts it
    acc2(1'b1, 32'h0000_0010, 32'hA5A5_0001);
    ena2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0010; wd2 = 32'h5A5A_0002;
    @(negedge clk);
    chk("abort_stall_c0", 32'(st2), 32'd1);
    @(posedge clk); #1;
    chk("abort_busy_c1", 32'(bz2), 32'd1);
    rst = 1'b1; ena2 = 1'b0;
    #1;
    chk("abort_stall", 32'(st2), 32'd0);
    chk("abort_busy", 32'(bz2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-write to 0x10");
    acc2(1'b0, 32'h0000_0010, 32'h0);

    // Write then read with two wait states
    acc2(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    acc2(1'b0, 32'h0000_0040, 32'h0);
    ena2 = 1'b0;

    // Flush during WAIT of a write
    @(posedge clk); #1;
    ena2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0040; wd2 = 32'h0BAD_F00D;
    @(negedge clk);
    chk("flush_stall_c0", 32'(st2), 32'd1);
    @(posedge clk); #1;
    ena2 = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", 32'(st2), 32'd0);
    chk("flush_busy_drop", 32'(bz2), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_busy_idle", 32'(bz2), 32'd0);
    @(posedge clk); #1;
    $display("flush of write to 0x40");
    acc2(1'b0, 32'h0000_0040, 32'h0);

    // Address wrap modulo DEPTH
    acc2(1'b1, 32'h0000_0400, 32'h1234_5678);
    acc2(1'b0, 32'h0000_0000, 32'h0);
    acc2(1'b0, 32'hFFFF_F040, 32'h0);
    ena2 = 1'b0;

    // Zero wait states: back-to-back single-cycle accesses
    acc0(1'b1, 32'h0000_0004, 32'hCAFE_0004);
    acc0(1'b1, 32'h0000_0008, 32'hCAFE_0008);
    acc0(1'b0, 32'h0000_0004, 32'h0);
    acc0(1'b0, 32'h0000_0008, 32'h0);
    acc0(1'b1, 32'h0000_0004, 32'h1111_2222);
    acc0(1'b0, 32'h0000_0004, 32'h0);
    ena0 = 1'b0;
    @(negedge clk);
    chk("idle_rdata0", rd0, 32'd0);
    @(posedge clk); #1;

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned write is retired immediately without touching memory
    ena2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0042; wd2 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mis_flag", 32'(mis2), 32'd1);
    chk("mis_stall", 32'(st2), 32'd0);
    chk("mis_busy", 32'(bz2), 32'd0);
    chk("mis_rdata", rd2, 32'd0);
    @(posedge clk); #1;
    $display("misaligned write addr=00000042");
    acc2(1'b0, 32'h0000_0040, 32'h0);
    ena2 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage pipeline. It is the far end of the M-stage memory controls `data_ram_ena` and `memwrite` that the controller drives.
- It services one word read or write per access, with a configurable number of wait states.
- While an access is outstanding it raises `mem_stall` toward the hazard logic so the pipeline holds the M-stage inputs stable.
- It sits beside the datapath, between the EM and MW pipeline registers.

Parameters:
- `DEPTH`, default 256: number of 32-bit words in the array; must be a power of two.
- `AW`, default 8: word-index width; log2(`DEPTH`).
- `WAIT_CYC`, default 2: wait states per access, legal range 0..15.

Ports:
- `clka`  input  1  clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data_ram_ena`  input  1  M-stage access request.
- `memwrite`  input  1  M-stage write select; 1 = write, 0 = read. Valid only with `data_ram_ena`.
- `addr`  input  32  byte address from the ALU result in M stage.
- `wdata`  input  32  M-stage store data.
- `rdata`  output  32  load data to the MW register.
- `mem_stall`  output  1  to hazard unit; while high, stall F/D/E/M and bubble W.
- `busy`  output  1  FSM is in WAIT.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE and the wait counter to 0.
  - `mem_stall`=0, `busy`=0, `rdata`=0 while `data_ram_ena`=0.
  - Array contents are not reset.
  - Reset mid-access aborts it: a pending write is never committed.
- Word index = `addr[AW+1:2]`.
  - Upper bits are ignored; addresses wrap modulo `DEPTH`.
  - `addr[1:0]` is ignored unless the optional feature is on.
- FSM states: IDLE, WAIT. Counter `cnt` is 4 bits.
- In IDLE:
  - If `data_ram_ena` && `WAIT_CYC`>0: next state WAIT, `cnt`<=`WAIT_CYC`-1.
  - If `data_ram_ena` && `WAIT_CYC`==0: the access completes this cycle and the FSM stays in IDLE.
- In WAIT:
  - If `cnt`!=0: `cnt`<=`cnt`-1.
  - If `cnt`==0: this is the completion cycle; next state is IDLE.
- `mem_stall` (combinational) = `data_ram_ena` && ((IDLE && `WAIT_CYC`!=0) || (WAIT && `cnt`!=0)).
- Timing: an access first seen at cycle T has `mem_stall` high during T..T+`WAIT_CYC`-1 and completes at cycle T+`WAIT_CYC` with `mem_stall` low. The pipeline advances on the edge that ends the completion cycle.
- Completion-cycle reads: `rdata` = mem[index], combinational from the array, and is valid only in the completion cycle. Outside it `rdata`=0.
- Completion-cycle writes: mem[index]<=`wdata` on the edge ending the completion cycle. `rdata` reads the old contents during that cycle.
- Exactly one array update per access. Wait cycles never write.
- Back-to-back accesses: if `data_ram_ena` is high in the cycle after a completion, it is a new access and the count restarts from IDLE.
  - With `WAIT_CYC`=0, every cycle with `data_ram_ena` high is an independent single-cycle access.
- Request dropped in WAIT (only legal on a pipeline flush): the FSM returns to IDLE next cycle with no write, and `mem_stall`=0 immediately.
- `addr`, `wdata` and `memwrite` changing during WAIT is a protocol violation. The values sampled in the completion cycle are used.

Optional Feature:
- Macro `DMEM_ALIGN_CHECK_EN`. When defined:
  - Adds output port `misalign`, 1 bit, asserted when `data_ram_ena` && `addr[1:0]`!=0.
  - A misaligned access completes in the same cycle with no wait states, `mem_stall`=0, no write, and `rdata`=0.
- When undefined: there is no `misalign` port and `addr[1:0]` is ignored.

Test Plan:
- Reset then idle: assert `rst` mid-WAIT of a write to addr 0x10 → `mem_stall`=0 and `busy`=0 immediately; a later read of 0x10 returns the prior contents.
- `WAIT_CYC`=2, write 0xDEADBEEF to 0x00000040 → `mem_stall` high for 2 cycles then low for 1; a following read of 0x40 → `mem_stall` high for 2 cycles, then `rdata`=0xDEADBEEF in the completion cycle.
- `WAIT_CYC`=0, back-to-back writes to 0x4 then 0x8 then reads of 0x4 and 0x8 → `mem_stall` never high; data returned matches the writes.
- Wrap-around with `DEPTH`=256: write 0x12345678 to 0x00000400, read 0x00000000 → 0x12345678.
- Flush: drop `data_ram_ena` during WAIT of a write → no array update, FSM back in IDLE next cycle, then a fresh read starts a full `WAIT_CYC` stall.
- `DMEM_ALIGN_CHECK_EN` defined: write to 0x00000042 → `misalign`=1, `mem_stall`=0, memory at 0x40 unchanged.
